// File: rtl/cache_mem_pkg.sv
// Shared types and helpers for the cache memory responder.
// Covers state encoding, default block geometry and address alignment.
package cache_mem_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT     = 3'd1,
    RD_BURST = 3'd2,
    WR_BURST = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam int unsigned BLOCK_WORDS_DEF = 4;
  localparam int unsigned BEAT_W          = $clog2(BLOCK_WORDS_DEF);
  localparam int unsigned OFFSET_W        = BEAT_W + 2;

  // Clear the low off_w bits so the address points at the block base.
  function automatic logic [63:0] align_addr(input logic [63:0] a,
                                             input int unsigned off_w);
    return a & ~((64'd1 << off_w) - 64'd1);
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-addressed backing store with per-word valid bits.
// A word that was never written reads back as its own byte address.
module mem_word_array #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH-1:0]      vld;
  logic [DEPTH_LOG2-1:0] idx;

  // Upper address bits alias onto the same word by design.
  assign idx = addr[DEPTH_LOG2+1:2];

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     vld      <= '0;
    else if (wr_en) vld[idx] <= 1'b1;
  end

  assign rdata = vld[idx] ? mem[idx] : DATA_W'(addr);

endmodule

// File: rtl/cache_mem_responder.sv
// Main-memory responder for cache line fills and dirty-line writebacks.
// Block-granular bursts behind a fixed programmable access latency.
module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int BLOCK_WORDS    = 4,
  parameter int LATENCY        = 4,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           mem_req,
  input  logic                           mem_we,
  input  logic [ADDR_W-1:0]              mem_addr,
  input  logic [DATA_W-1:0]              mem_wdata,
  input  logic                           mem_wvalid,
  output logic                           mem_wready,
  output logic [DATA_W-1:0]              mem_rdata,
  output logic                           mem_rvalid,
  output logic [$clog2(BLOCK_WORDS)-1:0] mem_beat,
  output logic                           mem_busy,
  output logic                           mem_done
);

  localparam int BEAT_BITS = $clog2(BLOCK_WORDS);
  localparam int OFF_BITS  = BEAT_BITS + 2;
  localparam int LAT_BITS  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_BITS-1:0]  LAT_LOAD  = (LATENCY > 0) ? LAT_BITS'(LATENCY - 1) : '0;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BLOCK_WORDS - 1);

  state_t                state, state_n;
  logic                  we_q;
  logic [ADDR_W-1:0]     base_q;
  logic [BEAT_BITS-1:0]  beat_q, beat_n;
  logic [LAT_BITS-1:0]   lat_q, lat_n;
  logic                  accept;
  logic                  wr_en;
  logic [ADDR_W-1:0]     word_addr;
  logic [DATA_W-1:0]     rd_data;

  assign accept = (state == IDLE) && mem_req;

  always_comb begin
    state_n = state;
    beat_n  = beat_q;
    lat_n   = lat_q;
    wr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          beat_n = '0;
          lat_n  = LAT_LOAD;
          if (LATENCY == 0) state_n = mem_we ? WR_BURST : RD_BURST;
          else              state_n = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == '0) state_n = we_q ? WR_BURST : RD_BURST;
        else             lat_n   = lat_q - LAT_BITS'(1);
      end
      RD_BURST: begin
        // Counter wraps back to 0 on the last beat (BLOCK_WORDS is a power of 2).
        beat_n = beat_q + BEAT_BITS'(1);
        if (beat_q == LAST_BEAT) state_n = DONE;
      end
      WR_BURST: begin
        if (mem_wvalid) begin
          wr_en  = 1'b1;
          beat_n = beat_q + BEAT_BITS'(1);
          if (beat_q == LAST_BEAT) state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      beat_q <= '0;
      lat_q  <= '0;
      we_q   <= 1'b0;
      base_q <= '0;
    end else begin
      state  <= state_n;
      beat_q <= beat_n;
      lat_q  <= lat_n;
      if (accept) begin
        we_q   <= mem_we;
        base_q <= ADDR_W'(align_addr(64'(mem_addr), OFF_BITS));
      end
    end
  end

  // Block never straddles the store wrap, so a plain add gives the word index.
  assign word_addr = base_q + ADDR_W'({beat_q, 2'b00});

  mem_word_array #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (MEM_DEPTH_LOG2)
  ) u_store (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (word_addr),
    .wr_en (wr_en),
    .wdata (mem_wdata),
    .rdata (rd_data)
  );

  assign mem_busy   = (state != IDLE);
  assign mem_done   = (state == DONE);
  assign mem_rvalid = (state == RD_BURST);
  assign mem_wready = (state == WR_BURST);
  assign mem_rdata  = mem_rvalid ? rd_data : '0;
  assign mem_beat   = (mem_rvalid || mem_wready) ? beat_q : '0;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Randomized scoreboard bench: dut_a uses LATENCY=4, dut_b uses LATENCY=0.
// Expected fill beats are queued at issue and checked by a separate monitor.
module tb_cache_mem_responder;

  localparam int AW = 32, DW = 32, BW = 4, LAT = 4, DL2 = 10;

  logic clk = 1'b0, rst_n = 1'b0;
  logic use_b = 1'b0;
  logic req_d = 1'b0, we_d = 1'b0, wvalid_d = 1'b0;
  logic [AW-1:0] addr_d = '0;
  logic [DW-1:0] wdata_d = '0;

  logic a_req, a_wvalid, a_wready, a_rvalid, a_busy, a_done;
  logic b_req, b_wvalid, b_wready, b_rvalid, b_busy, b_done;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [1:0] a_beat, b_beat;
  logic cur_rvalid, cur_wready, cur_done, cur_busy;
  logic [1:0] cur_beat;

  assign a_req    = req_d & ~use_b;
  assign b_req    = req_d & use_b;
  assign a_wvalid = wvalid_d & ~use_b;
  assign b_wvalid = wvalid_d & use_b;
  assign cur_rvalid = use_b ? b_rvalid : a_rvalid;
  assign cur_wready = use_b ? b_wready : a_wready;
  assign cur_done   = use_b ? b_done   : a_done;
  assign cur_busy   = use_b ? b_busy   : a_busy;
  assign cur_beat   = use_b ? b_beat   : a_beat;

  cache_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .BLOCK_WORDS(BW), .LATENCY(LAT),
                        .MEM_DEPTH_LOG2(DL2)) dut_a (
    .clk(clk), .rst_n(rst_n), .mem_req(a_req), .mem_we(we_d), .mem_addr(addr_d),
    .mem_wdata(wdata_d), .mem_wvalid(a_wvalid), .mem_wready(a_wready),
    .mem_rdata(a_rdata), .mem_rvalid(a_rvalid), .mem_beat(a_beat),
    .mem_busy(a_busy), .mem_done(a_done));

  cache_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .BLOCK_WORDS(BW), .LATENCY(0),
                        .MEM_DEPTH_LOG2(DL2)) dut_b (
    .clk(clk), .rst_n(rst_n), .mem_req(b_req), .mem_we(we_d), .mem_addr(addr_d),
    .mem_wdata(wdata_d), .mem_wvalid(b_wvalid), .mem_wready(b_wready),
    .mem_rdata(b_rdata), .mem_rvalid(b_rvalid), .mem_beat(b_beat),
    .mem_busy(b_busy), .mem_done(b_done));

  typedef struct packed { logic [31:0] data; logic [1:0] beat; } exp_t;
  exp_t qa[$], qb[$];
  logic [31:0] model [int];
  int total = 0, bad = 0, cyc = 0, na_done = 0, nb_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference store: words alias on index; never-written words read as their address.
  function automatic logic [31:0] ref_word(input logic [31:0] byte_addr);
    int k;
    k = int'((byte_addr >> 2) & ((32'd1 << DL2) - 1));
    return model.exists(k) ? model[k] : byte_addr;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (a_rvalid) begin
      if (qa.size() == 0) chk("a_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        e = qa.pop_front();
        chk("a_rdata", a_rdata, e.data);
        chk("a_beat", 32'(a_beat), 32'(e.beat));
      end
    end
    if (b_rvalid) begin
      if (qb.size() == 0) chk("b_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        e = qb.pop_front();
        chk("b_rdata", b_rdata, e.data);
        chk("b_beat", 32'(b_beat), 32'(e.beat));
      end
    end
    if (a_done) na_done++;
    if (b_done) nb_done++;
  end

  task automatic do_fill(input logic sel, input logic [31:0] addr, input bit drop_mid);
    logic [31:0] base;
    int e0, first, dn, lat;
    exp_t e;
    base = addr & ~32'hF;
    lat  = sel ? 0 : LAT;
    @(negedge clk);
    use_b = sel; req_d = 1'b1; we_d = 1'b0; addr_d = addr;
    for (int i = 0; i < BW; i++) begin
      e.data = sel ? base + 32'(4 * i) : ref_word(base + 32'(4 * i));
      e.beat = 2'(i);
      if (sel) qb.push_back(e); else qa.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    e0 = cyc; first = -1; dn = -1;
    for (int n = 0; n < 100; n++) begin
      if (cur_rvalid && first < 0) first = cyc;
      if (drop_mid && cur_rvalid && cur_beat == 2'd1) req_d = 1'b0;
      if (cur_done) begin dn = cyc; req_d = 1'b0; break; end
      @(negedge clk);
    end
    req_d = 1'b0;
    chk("fill_first_beat_lat", 32'(first - e0), 32'(lat));
    chk("fill_done_lat", 32'(dn - e0), 32'(lat + BW));
  endtask

  task automatic do_wb(input logic [31:0] addr, input logic [3:0][31:0] d,
                       input int stall_beat, input int stall_n);
    logic [31:0] base;
    int e0, dn, k, st;
    base = addr & ~32'hF;
    @(negedge clk);
    use_b = 1'b0; req_d = 1'b1; we_d = 1'b1; addr_d = addr; wvalid_d = 1'b0;
    @(posedge clk);
    @(negedge clk);
    e0 = cyc; dn = -1; k = 0; st = stall_n;
    for (int n = 0; n < 200; n++) begin
      if (cur_done) begin dn = cyc; break; end
      if (cur_wready && k < BW) begin
        chk("wb_beat", 32'(cur_beat), 32'(k));
        if (k == stall_beat && st > 0) begin
          wvalid_d = 1'b0; st--;
        end else begin
          wvalid_d = 1'b1; wdata_d = d[k];
          model[int'(((base >> 2) + 32'(k)) & ((32'd1 << DL2) - 1))] = d[k];
          k++;
        end
      end else wvalid_d = 1'b0;
      @(negedge clk);
    end
    req_d = 1'b0; wvalid_d = 1'b0; we_d = 1'b0;
    chk("wb_done_lat", 32'(dn - e0), 32'(LAT + BW + stall_n));
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] hi;
    hi = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'h4000_0000;
    return hi | (32'($urandom_range(0, 15)) << 4) | 32'($urandom_range(0, 15));
  endfunction

  initial begin
    logic [3:0][31:0] d;
    int c;
    #1;
    chk("reset_outputs", {a_rdata, a_rvalid, a_wready, a_beat, a_busy, a_done}, 32'd0);
    chk("reset_outputs_b", {b_rdata, b_rvalid, b_wready, b_beat, b_busy, b_done}, 32'd0);
    #20;
    @(negedge clk) rst_n = 1'b1;

    do_fill(1'b0, 32'h8000_0000, 1'b0);
    d = {32'h0, 32'h0, 32'hAABB_CCDD, 32'h1234_5678};
    do_wb(32'h8000_0000, d, 0, 0);
    do_fill(1'b0, 32'h8000_0000, 1'b0);
    d = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
    do_wb(32'h8000_0040, d, 2, 2);
    do_fill(1'b0, 32'h8000_0040, 1'b0);
    do_fill(1'b1, 32'h8000_000C, 1'b0);

    c = na_done;
    do_fill(1'b0, 32'h8000_0000, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("drop_req_done_once", 32'(na_done - c), 32'd1);
    chk("drop_req_idle", 32'(a_busy), 32'd0);

    // Reset while waiting out the latency; written words must be forgotten.
    @(negedge clk);
    use_b = 1'b0; req_d = 1'b1; we_d = 1'b0; addr_d = 32'h8000_0000;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("busy_in_wait", 32'(a_busy), 32'd1);
    rst_n = 1'b0; req_d = 1'b0;
    #1;
    chk("async_reset_outputs", {a_rdata, a_rvalid, a_wready, a_beat, a_busy, a_done}, 32'd0);
    model.delete();
    @(negedge clk) rst_n = 1'b1;
    do_fill(1'b0, 32'h8000_0000, 1'b0);
    do_fill(1'b0, 32'h8000_0040, 1'b0);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: do_fill(1'b0, rand_addr(), 1'b0);
        1: begin
          for (int i = 0; i < BW; i++) d[i] = $urandom;
          do_wb(rand_addr(), d, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        default: do_fill(1'b1, rand_addr(), 1'b0);
      endcase
    end

    repeat (4) @(negedge clk);
    chk("queue_a_drained", 32'(qa.size()), 32'd0);
    chk("queue_b_drained", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
